// File: rtl/systolic_mm_engine.sv
// Output-stationary NxN systolic matrix multiply: C = sat((A*B [+ acc]) >>> SHIFT).
// A rows and B columns enter skewed from the left and top edges; each PE owns one accumulator.
module systolic_mm_engine #(
    parameter int N      = 10,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 2*DATA_W + $clog2(N) + 1,
    parameter int SHIFT  = 0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic                                    acc_mode,
    input  logic signed [N-1:0][N-1:0][DATA_W-1:0]  A,
    input  logic signed [N-1:0][N-1:0][DATA_W-1:0]  B,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    ovf,
    output logic signed [N-1:0][N-1:0][DATA_W-1:0]  C
);

    localparam int CW = $clog2(3*N - 2);
    localparam int PW = 2*DATA_W;
    localparam logic [CW-1:0] CNT_LAST = CW'(3*N - 3);
    localparam logic signed [ACC_W-1:0] C_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [CW-1:0]              cnt;
    logic                       acc_mode_q;
    logic                       any_clamp;
    logic signed [DATA_W-1:0]   a_in   [N][N];
    logic signed [DATA_W-1:0]   b_in   [N][N];
    logic signed [DATA_W-1:0]   a_reg  [N][N-1];
    logic signed [DATA_W-1:0]   b_reg  [N-1][N];
    logic signed [PW-1:0]       prod   [N][N];
    logic signed [ACC_W-1:0]    acc    [N][N];
    logic signed [ACC_W-1:0]    acc_nx [N][N];
    logic signed [ACC_W-1:0]    sh     [N][N];
    logic [DATA_W-1:0]          sat_v  [N][N];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: if (start) state_nx = LOAD;
            LOAD: begin
                busy     = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Edge injection: A[i][k] reaches column 0 and B[k][j] reaches row 0 on counter k+i / k+j.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = '0;
            b_in[0][i] = '0;
            for (int k = 0; k < N; k++) begin
                if (int'(cnt) == i + k) begin
                    a_in[i][0] = $signed(A[i][k]);
                    b_in[0][i] = $signed(B[k][i]);
                end
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = 1; j < N; j++)
                a_in[i][j] = a_reg[i][j-1];
        for (int i = 1; i < N; i++)
            for (int j = 0; j < N; j++)
                b_in[i][j] = b_reg[i-1][j];
    end

    // acc_nx includes the product being added this cycle so the final MAC is in C.
    always_comb begin
        any_clamp = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod[i][j]   = PW'(a_in[i][j]) * PW'(b_in[i][j]);
                acc_nx[i][j] = acc[i][j] + ACC_W'(prod[i][j]);
                sh[i][j]     = acc_nx[i][j] >>> SHIFT;
                if (sh[i][j] > C_MAX) begin
                    sat_v[i][j] = C_MAX[DATA_W-1:0];
                    any_clamp   = 1'b1;
                end else if (sh[i][j] < C_MIN) begin
                    sat_v[i][j] = C_MIN[DATA_W-1:0];
                    any_clamp   = 1'b1;
                end else begin
                    sat_v[i][j] = sh[i][j][DATA_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            acc_mode_q <= 1'b0;
            ovf        <= 1'b0;
            C          <= '0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    acc[i][j] <= '0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N-1; j++)
                    a_reg[i][j] <= '0;
            for (int i = 0; i < N-1; i++)
                for (int j = 0; j < N; j++)
                    b_reg[i][j] <= '0;
        end else begin
            if (state == IDLE && start) begin
                acc_mode_q <= acc_mode;
                ovf        <= 1'b0;
            end
            if (state == LOAD)     cnt <= '0;
            else if (state == RUN) cnt <= cnt + CW'(1);

            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (state == RUN)                     acc[i][j] <= acc_nx[i][j];
                    else if (state == LOAD && !acc_mode_q) acc[i][j] <= '0;
            // Pipelines are zeroed outside RUN so every run starts from clean padding.
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N-1; j++)
                    a_reg[i][j] <= (state == RUN) ? a_in[i][j] : '0;
            for (int i = 0; i < N-1; i++)
                for (int j = 0; j < N; j++)
                    b_reg[i][j] <= (state == RUN) ? b_in[i][j] : '0;

            if (state == RUN && cnt == CNT_LAST) begin
                ovf <= any_clamp;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        C[i][j] <= sat_v[i][j];
            end
        end
    end

endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
- Parametrised output-stationary NxN systolic matrix-multiply engine computing C = sat((A·B [+ previous accumulators]) >>> SHIFT).
- Generalises the fixed 10x10 single-matrix systolic_array in three ways: matrix size, data width and output scaling are parameters; it takes two operand matrices; it adds an accumulate mode, saturation and an overflow flag.
- Sits between the NPU matrix buffers and the activation stage, using the same start/done handshake as systolic_array.

Parameters:
- N, 10, matrix dimension (N>=2).
- DATA_W, 16, signed width of A, B and C elements.
- ACC_W, 2*DATA_W+$clog2(N)+1, signed width of the per-PE accumulator.
- SHIFT, 0, arithmetic right shift applied to accumulators before saturation (0..ACC_W-1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a run; sampled only in IDLE.
- acc_mode  in  1  sampled with start; 1 = keep accumulators (C += A·B), 0 = clear them first.
- A  in  signed DATA_W, [N-1:0][N-1:0]  left operand; held stable by the driver from start until done.
- B  in  signed DATA_W, [N-1:0][N-1:0]  right operand; same stability rule as A.
- busy  out  1  high in LOAD and RUN.
- done  out  1  one-cycle pulse; C is valid from this cycle onward.
- ovf  out  1  sticky; set if any element of C saturated during the last run.
- C  out  signed DATA_W, [N-1:0][N-1:0]  result register, held until the next done.

Behaviour:
- Reset: synchronous, active-high, one clock. It forces state=IDLE and clears every accumulator, every skew/pipeline register, the counter, C, busy, done and ovf to 0. Reset asserted mid-run aborts the run and C shows 0, not a partial result.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE→LOAD: on an edge where start=1. The same edge latches acc_mode and clears ovf.
  - start=1 in any state other than IDLE is ignored; no queuing.
- LOAD→RUN: always, after 1 cycle. On this edge, if the latched acc_mode=0, all accumulators are cleared. The cycle counter is set to 0.
- RUN: lasts 3N-2 cycles (counter 0..3N-3). RUN→DONE on the edge where counter=3N-3.
  - Row i of A enters PE(i,0) delayed by i cycles. Column j of B enters PE(0,j) delayed by j cycles.
  - Padding outside the valid window is zero.
  - Each PE does acc += a·b (full-precision signed product, sign-extended to ACC_W), then forwards a to the right and b downward with one register stage.
  - PE(i,j) receives its last valid pair on counter i+j+N-1. The maximum is 3N-3, so all PEs finish within RUN.
- Entering DONE: C[i][j] = saturate(acc[i][j] >>> SHIFT) to the signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Rounding: truncation toward -inf (arithmetic shift).
  - ovf is set if any element was clamped.
  - done=1 for exactly the DONE cycle.
- DONE→IDLE: always, after 1 cycle. Accumulators retain their values, which feed an acc_mode=1 run.
- Latency: if start is sampled on edge E0, done is high in the cycle after edge E0+3N-1, i.e. 29 edges for N=10. busy is high in the cycle after E0 through the cycle after E0+3N-2.
- Back-to-back: start may be asserted in the cycle done=1 but is only accepted once the FSM is back in IDLE, so at minimum the next run starts one cycle after done.
- A or B changing while busy=1 gives undefined results; this is not checked.

Test Plan:
- Identity: N=4, A=I, B=[[1..4],[5..8],[9..12],[13..16]], acc_mode=0 → C equals B exactly, ovf=0, done exactly 3N-1=11 edges after the start edge.
- Saturation: N=4, A all 200, B all 100, SHIFT=0 → each accumulator holds 80000, C all 32767, ovf=1. Rerun with SHIFT=4 → C all 5000, ovf=0.
- Negative clamp and N=10 regression: N=10, A all -300, B all 200, SHIFT=0 → C all -32768, ovf=1. Then the 10x10 mixed matrix times the 100/200 checkerboard, compared against a bench reference model with SHIFT=4.
- Accumulate: N=4, A=I, B all 7, acc_mode=0 → C all 7. Second run, same operands, acc_mode=1 → C all 14. Third run, acc_mode=0 → C all 7.
- Handshake: pulse start again at RUN counter=5 → ignored, exactly one done pulse. Hold start high continuously → runs repeat with period 3N+1 cycles and done is never high for more than 1 cycle.
- Reset mid-run: assert rst for 1 cycle at RUN counter=4 → next cycle busy=0, done=0, ovf=0, C all 0. A following acc_mode=1 run gives pure A·B, since the accumulators were cleared.
